// File: rtl/vga_capture.sv
// vga_capture: locks onto VGA sync timing and writes active pixels to frame memory.
// Ports: Clock/Reset, h_sync/v_sync/blank/R/G/B in; WrEn/WrAddr/WrData, Locked, SyncErr, FrameDone, HTotal/VTotal out.
module vga_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19,
  parameter int TIMEOUT  = 4095
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              h_sync,
  input  logic              v_sync,
  input  logic              blank,
  input  logic [7:0]        R,
  input  logic [7:0]        G,
  input  logic [7:0]        B,
  output logic              WrEn,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [23:0]       WrData,
  output logic              Locked,
  output logic              SyncErr,
  output logic              FrameDone,
  output logic [11:0]       HTotal,
  output logic [10:0]       VTotal
);

  typedef enum logic [1:0] {
    UNLOCKED,
    MEASURE,
    CHECK,
    LOCKED
  } state_t;

  localparam logic [11:0]       TO = 12'(TIMEOUT);
  localparam logic [11:0]       HX = 12'(H_ACTIVE);
  localparam logic [10:0]       VY = 11'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] HA = ADDR_W'(H_ACTIVE);

  state_t      state;
  logic        hs1, vs1, bl1, hs2, vs2;
  logic [23:0] rgb1;
  logic [11:0] hcnt, last_len, x;
  logic [10:0] vcnt, y;
  logic        act;

  logic        hfall, vfall;
  logic [11:0] line_len, x_cur;
  logic [10:0] frame_len, y_cur;
  logic        h_bad, v_bad, tmo;
  logic        enter, keep, lock_n;
  logic [ADDR_W-1:0] addr;

  assign hfall     = hs2 & ~hs1;
  assign vfall     = vs2 & ~vs1;
  assign line_len  = hfall ? hcnt : last_len;
  assign frame_len = vcnt + 11'd1;
  assign h_bad     = hfall & (hcnt != HTotal);
  assign v_bad     = vfall & (frame_len != VTotal);
  assign tmo       = hcnt >= TO;

  // lock_n is the Locked value for the next cycle; gating writes
  // with it keeps WrEn and Locked changing on the same edge.
  assign enter  = (state == CHECK) & vfall & ~h_bad & ~v_bad;
  assign keep   = (state == LOCKED) & ~(h_bad | v_bad | tmo);
  assign lock_n = enter | keep;

  // Coordinates of the pixel currently in s1.
  assign x_cur = hfall ? 12'd0 : x;

  always_comb begin
    y_cur = y;
    if (vfall)
      y_cur = 11'd0;
    else if (hfall && act && y != 11'h7FF)
      y_cur = y + 11'd1;
  end

  assign addr = ADDR_W'(y_cur) * HA + ADDR_W'(x_cur);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      hs1      <= 1'b0;
      vs1      <= 1'b0;
      bl1      <= 1'b0;
      hs2      <= 1'b0;
      vs2      <= 1'b0;
      rgb1     <= 24'd0;
      hcnt     <= 12'd0;
      last_len <= 12'd0;
      vcnt     <= 11'd0;
      x        <= 12'd0;
      y        <= 11'd0;
      act      <= 1'b0;
      WrEn     <= 1'b0;
      WrAddr   <= '0;
      WrData   <= 24'd0;
    end else begin
      hs1  <= h_sync;
      vs1  <= v_sync;
      bl1  <= blank;
      rgb1 <= {R, G, B};
      hs2  <= hs1;
      vs2  <= vs1;

      if (hfall)
        hcnt <= 12'd1;
      else if (hcnt != 12'hFFF)
        hcnt <= hcnt + 12'd1;

      if (hfall)
        last_len <= hcnt;

      if (vfall)
        vcnt <= 11'd0;
      else if (hfall)
        vcnt <= vcnt + 11'd1;

      if (x_cur != 12'hFFF)
        x <= x_cur + {11'd0, bl1};
      else
        x <= x_cur;
      y   <= y_cur;
      act <= hfall ? bl1 : (act | bl1);

      WrEn   <= lock_n & bl1 & (x_cur < HX) & (y_cur < VY);
      WrAddr <= addr;
      WrData <= rgb1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= UNLOCKED;
      Locked    <= 1'b0;
      SyncErr   <= 1'b0;
      FrameDone <= 1'b0;
      HTotal    <= 12'd0;
      VTotal    <= 11'd0;
    end else begin
      Locked    <= lock_n;
      FrameDone <= vfall & lock_n;
      SyncErr   <= 1'b0;
      unique case (state)
        UNLOCKED: begin
          if (vfall)
            state <= MEASURE;
        end
        MEASURE: begin
          if (vfall) begin
            HTotal <= line_len;
            VTotal <= frame_len;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (vfall) begin
            if (h_bad || v_bad) begin
              HTotal <= line_len;
              VTotal <= frame_len;
              state  <= MEASURE;
            end else begin
              state <= LOCKED;
            end
          end else if (h_bad) begin
            HTotal <= hcnt;
            state  <= MEASURE;
          end
        end
        LOCKED: begin
          if (h_bad || v_bad || tmo) begin
            state   <= UNLOCKED;
            SyncErr <= 1'b1;
          end
        end
        default: state <= UNLOCKED;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: random-pixel VGA frames against a frame-level capture model.
// Drives sync/pixel pins, scoreboards writes, lock, SyncErr and FrameDone.
module tb_vga_capture;

  localparam int HA   = 16;
  localparam int VA   = 8;
  localparam int AW   = 8;
  localparam int TO   = 100;
  localparam int HT   = 40;
  localparam int HSW  = 6;
  localparam int VT   = 14;
  localparam int VSW  = 2;
  localparam int ROW0 = 3;
  localparam int ROW1 = 12;
  localparam int NPIX = 18;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          h_sync = 1'b1;
  logic          v_sync = 1'b1;
  logic          blank = 1'b0;
  logic [7:0]    R = 8'd0;
  logic [7:0]    G = 8'd0;
  logic [7:0]    B = 8'd0;
  logic          WrEn;
  logic [AW-1:0] WrAddr;
  logic [23:0]   WrData;
  logic          Locked;
  logic          SyncErr;
  logic          FrameDone;
  logic [11:0]   HTotal;
  logic [10:0]   VTotal;

  vga_capture #(
    .H_ACTIVE(HA),
    .V_ACTIVE(VA),
    .ADDR_W(AW),
    .TIMEOUT(TO)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .h_sync(h_sync),
    .v_sync(v_sync),
    .blank(blank),
    .R(R),
    .G(G),
    .B(B),
    .WrEn(WrEn),
    .WrAddr(WrAddr),
    .WrData(WrData),
    .Locked(Locked),
    .SyncErr(SyncErr),
    .FrameDone(FrameDone),
    .HTotal(HTotal),
    .VTotal(VTotal)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int          addr;
    logic [23:0] data;
    int          stamp;
  } wr_t;

  wr_t q[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_err = 0;
  int  n_wr = 0;
  int  n_se = 0;
  int  n_fd = 0;
  int  exp_wr = 0;
  int  exp_se = 0;
  int  exp_fd = 0;
  // Clean vfalls seen since the last upset / since the last reset.
  int  since = 0;
  int  since_rst = 0;
  bit  m_lock = 1'b0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge Clock) begin : mon
    wr_t e;
    if (Reset) begin
      if (WrEn) begin
        n_wr++;
        chk("wr_locked", 32'(Locked), 32'd1);
        if (q.size() == 0) begin
          chk("wr_unexp", 32'(WrEn), 32'd0);
        end else begin
          e = q.pop_front();
          chk("wr_addr", 32'(WrAddr), 32'(e.addr));
          chk("wr_data", 32'(WrData), 32'(e.data));
          chk("wr_lat", 32'(cyc - e.stamp), 32'd2);
        end
      end
      if (SyncErr) begin
        n_se++;
        chk("se_unlock", 32'(Locked), 32'd0);
      end
      if (FrameDone) n_fd++;
    end
  end

  task automatic tick(input logic hs, input logic vs, input logic bl,
                      input logic [23:0] px);
    @(negedge Clock);
    h_sync = hs;
    v_sync = vs;
    blank  = bl;
    {R, G, B} = px;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wren"}, 32'(WrEn), 32'd0);
    chk({tag, "_addr"}, 32'(WrAddr), 32'd0);
    chk({tag, "_data"}, 32'(WrData), 32'd0);
    chk({tag, "_lock"}, 32'(Locked), 32'd0);
    chk({tag, "_serr"}, 32'(SyncErr), 32'd0);
    chk({tag, "_fdone"}, 32'(FrameDone), 32'd0);
    chk({tag, "_htot"}, 32'(HTotal), 32'd0);
    chk({tag, "_vtot"}, 32'(VTotal), 32'd0);
  endtask

  // kind: 0 clean, 1 short line, 2 stuck h_sync, 3 reset mid-frame
  task automatic frame(input int kind, input int bad_row);
    int yy;
    int len;
    int st;
    int xx;
    bit had;
    logic on;
    logic [23:0] px;
    wr_t e;
    yy = 0;
    since++;
    since_rst++;
    m_lock = (since >= 3);
    if (m_lock) exp_fd++;
    for (int r = 0; r < VT; r++) begin
      len = HT;
      st  = int'($urandom_range(10, 13));
      had = 1'b0;
      if (kind == 1 && r == bad_row) len = int'($urandom_range(20, 36));
      if (kind == 2 && r == bad_row) len = 3 * TO;
      for (int c = 0; c < len; c++) begin
        on = (r >= ROW0 && r <= ROW1 && c >= st && c < st + NPIX);
        px = on ? 24'($urandom) : 24'h0;
        tick(c >= HSW, r >= VSW, on, px);
        xx = c - st;
        if (on) had = 1'b1;
        if (on && m_lock && xx < HA && yy < VA) begin
          e.addr  = (yy * HA + xx) % (1 << AW);
          e.data  = px;
          e.stamp = cyc;
          q.push_back(e);
          exp_wr++;
        end
        if (c == 20) begin
          chk("locked", 32'(Locked), 32'(m_lock));
          if (r == 0) begin
            chk("htotal", 32'(HTotal), (since_rst >= 2) ? 32'(HT) : 32'd0);
            chk("vtotal", 32'(VTotal), (since_rst >= 2) ? 32'(VT) : 32'd0);
          end
        end
        if (kind == 3 && r == bad_row && c == 35) begin
          #2 Reset = 1'b0;
          #1 chk_zero("rst_mid");
          chk("rst_qempty", 32'(q.size()), 32'd0);
          since = 0;
          since_rst = 0;
          m_lock = 1'b0;
          @(negedge Clock);
          #2 Reset = 1'b1;
        end
      end
      if (had) yy++;
      if ((kind == 1 || kind == 2) && r == bad_row) begin
        since = 0;
        m_lock = 1'b0;
        exp_se++;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge Clock);
    #1 chk_zero("rst");
    #1 Reset = 1'b1;
    repeat (5) tick(1'b1, 1'b1, 1'b0, 24'h0);
    repeat (4) frame(0, 0);
    frame(1, int'($urandom_range(4, 9)));
    repeat (3) frame(0, 0);
    frame(2, int'($urandom_range(4, 9)));
    repeat (3) frame(0, 0);
    frame(3, 7);
    repeat (4) frame(0, 0);
    repeat (4) tick(1'b1, 1'b1, 1'b0, 24'h0);
    chk("end_locked", 32'(Locked), 32'd1);
    chk("n_fdone", 32'(n_fd), 32'(exp_fd));
    chk("n_serr", 32'(n_se), 32'(exp_se));
    chk("n_writes", 32'(n_wr), 32'(exp_wr));
    chk("q_left", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receiving end of the team's VGA timing/pixel interface: consumes h_sync, v_sync, blank and 8-bit R/G/B from a VGA source.
- Recovers line and frame timing, locks onto it, and writes active pixels into frame memory as address/data/write-enable.
- Sits between a VGA source (timing generator or external video) and the frame-buffer memory block.

Parameters:
H_ACTIVE, 640, active pixels stored per line; x >= H_ACTIVE is clipped
V_ACTIVE, 480, active lines stored per frame; y >= V_ACTIVE is clipped
ADDR_W, 19, width of WrAddr
TIMEOUT, 4095, max clocks between h_sync falling edges before loss of lock

Ports:
Clock  in  1  pixel clock, all logic on rising edge
Reset  in  1  asynchronous, active-low reset
h_sync  in  1  horizontal sync, active low
v_sync  in  1  vertical sync, active low
blank  in  1  1 = active video, 0 = blanking
R  in  8  red
G  in  8  green
B  in  8  blue
WrEn  out  1  memory write strobe, one pixel per cycle
WrAddr  out  ADDR_W  y*H_ACTIVE + x
WrData  out  24  {R,G,B}
Locked  out  1  timing locked, writes enabled
SyncErr  out  1  one-cycle pulse on loss of lock
FrameDone  out  1  one-cycle pulse at v_sync falling edge while Locked
HTotal  out  12  measured clocks per line
VTotal  out  11  measured lines per frame

Behaviour:
- Reset low (async): all outputs 0, FSM = UNLOCKED, all counters 0.
- Input stage: h_sync, v_sync, blank and RGB registered once (s1). Edges are detected on s1 versus its previous value.
- hfall = h_sync s1 1->0. vfall = v_sync s1 1->0. A vfall and hfall in the same cycle is legal and is the normal case.
- hcnt (12b):
  - hfall: set to 1.
  - otherwise: increments, saturating at 4095.
- vcnt (11b):
  - vfall: set to 0.
  - each hfall: increments.
- Measurement: on each hfall, line length = hcnt before the reset. On each vfall, frame length = vcnt + 1.
- FSM states:
  - UNLOCKED: on vfall -> MEASURE.
  - MEASURE: accumulate. On next vfall, latch HTotal = last line length and VTotal = frame length -> CHECK.
  - CHECK: every line length must equal HTotal.
    - Next vfall with frame length == VTotal -> LOCKED.
    - Any mismatch (line or frame) -> MEASURE, re-latching the new values.
  - LOCKED:
    - Line length != HTotal, frame length != VTotal, or hcnt reaching TIMEOUT -> UNLOCKED.
    - SyncErr pulses for 1 cycle on that transition.
- Pixel coordinates:
  - x: reset to 0 on hfall; increments after each cycle with blank s1 = 1.
  - y: reset to 0 on vfall. On hfall, increments only if the line just ended had at least one active pixel.
- Write rule:
  - WrEn = Locked & blank s1 & x < H_ACTIVE & y < V_ACTIVE.
  - WrAddr = y*H_ACTIVE + x, truncated to ADDR_W.
  - WrData = s1 RGB.
  - All three are registered outputs.
- Latency: 2 clocks from pins to WrEn/WrAddr/WrData.
- WrEn is never asserted in the cycle Locked drops, and never before the LOCKED entry cycle.
- FrameDone: pulses on vfall while in LOCKED, including the cycle of entry into LOCKED.
- Reset mid-frame: immediate return to reset values; a fresh lock then requires 3 vfalls.

Test Plan:
- Drive standard source timing (795 clk/line, 526 lines/frame, h_sync low 95 clk, v_sync low 2 lines, active cols 140..778, rows 35..515) -> HTotal = 795, VTotal = 526 after 2nd vfall; Locked rises at 3rd vfall; zero WrEn before that.
- Locked frame, RGB = 0x123456 at col 140 row 35 -> 2 clk later WrEn = 1, WrAddr = 0, WrData = 0x123456.
- Full locked frame -> exactly 639*480 = 306720 WrEn pulses. Last address 479*640+638 = 307198. Row 481 (y = 480) produces no writes. One FrameDone.
- While Locked, shorten one line to 700 clk -> SyncErr 1-cycle pulse, Locked = 0, no writes. Relock after 2 more clean frames, i.e. at the 3rd following vfall.
- Hold h_sync high for 5000 clk while Locked -> SyncErr at hcnt = 4095, Locked = 0.
- Assert Reset low at mid-frame pixel (300,200) -> all outputs 0 asynchronously. After release, Locked only after 3 vfalls.
